// File: rtl/conv_loop_counter.sv
// Convolution loop-index datapath: output/input channel and patch position counters.
// Optional strobe sequencing checker: define CONV_LOOP_STROBE_CHECK_EN to add seq_err.
module conv_loop_counter #(
    parameter  int IMG_W  = 28,
    parameter  int IMG_H  = 28,
    parameter  int K      = 3,
    parameter  int STRIDE = 1,
    parameter  int CH_W   = 8,
    localparam int OUT_W  = (IMG_W - K) / STRIDE + 1,
    localparam int OUT_H  = (IMG_H - K) / STRIDE + 1,
    localparam int RW     = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int CW     = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cout,
    input  logic            c_load,
    input  logic            bias_init,
    input  logic            cin,
    input  logic            conv,
    input  logic            relu,
    input  logic [CH_W-1:0] cfg_num_in_ch,
    input  logic [CH_W-1:0] cfg_num_out_ch,
    output logic            conv_done,
    output logic            cin_done,
    output logic            cout_done,
    output logic            is_single_input_channel,
    output logic [CH_W-1:0] in_ch_idx,
    output logic [CH_W-1:0] out_ch_idx,
    output logic [RW-1:0]   patch_row,
    output logic [CW-1:0]   patch_col,
    output logic [31:0]     patch_base_addr,
`ifdef CONV_LOOP_STROBE_CHECK_EN
    output logic            seq_err,
`endif
    output logic            patch_valid
);

    localparam logic [RW-1:0]   ROW_LAST = RW'(OUT_H - 1);
    localparam logic [CW-1:0]   COL_LAST = CW'(OUT_W - 1);
    localparam logic [CH_W-1:0] ONE      = CH_W'(1);

    logic [CH_W-1:0] n_in_q, n_in_d;
    logic [CH_W-1:0] n_out_q, n_out_d;
    logic [CH_W-1:0] in_cnt_q, in_cnt_d;
    logic [CH_W-1:0] in_ch_q, in_ch_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;

    logic row_last;
    logic col_last;
    logic in_left;

    // bias_init and relu only sequence the controller; they never move counters
    logic unused_strobes;
    assign unused_strobes = bias_init ^ relu;

    assign row_last = (row_q == ROW_LAST);
    assign col_last = (col_q == COL_LAST);
    assign in_left  = (in_cnt_q < n_in_q);

    assign is_single_input_channel = (n_in_q == ONE);
    assign cin_done  = (in_cnt_q == n_in_q) && !is_single_input_channel;
    assign cout_done = (out_ch_q == n_out_q - ONE);
    assign conv_done = conv && row_last && col_last;

    assign in_ch_idx   = in_ch_q;
    assign out_ch_idx  = out_ch_q;
    assign patch_row   = row_q;
    assign patch_col   = col_q;
    assign patch_valid = conv;

    assign patch_base_addr = 32'(row_q) * 32'(STRIDE * IMG_W)
                           + 32'(col_q) * 32'(STRIDE);

    always_comb begin
        n_in_d   = n_in_q;
        n_out_d  = n_out_q;
        in_cnt_d = in_cnt_q;
        in_ch_d  = in_ch_q;
        out_ch_d = out_ch_q;
        row_d    = row_q;
        col_d    = col_q;
        // priority c_load > cout > cin > conv
        if (c_load) begin
            n_in_d   = (cfg_num_in_ch == '0) ? ONE : cfg_num_in_ch;
            n_out_d  = (cfg_num_out_ch == '0) ? ONE : cfg_num_out_ch;
            in_cnt_d = '0;
            in_ch_d  = '0;
            row_d    = '0;
            col_d    = '0;
        end else if (cout) begin
            if (out_ch_q < n_out_q - ONE) begin
                out_ch_d = out_ch_q + ONE;
            end
        end else if (cin) begin
            if (in_left) begin
                in_ch_d  = in_cnt_q;
                in_cnt_d = in_cnt_q + ONE;
                row_d    = '0;
                col_d    = '0;
            end
        end else if (conv) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_in_q   <= ONE;
            n_out_q  <= ONE;
            in_cnt_q <= '0;
            in_ch_q  <= '0;
            out_ch_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            n_in_q   <= n_in_d;
            n_out_q  <= n_out_d;
            in_cnt_q <= in_cnt_d;
            in_ch_q  <= in_ch_d;
            out_ch_q <= out_ch_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

`ifdef CONV_LOOP_STROBE_CHECK_EN
    logic seq_err_q, seq_err_d;
    logic bad_seq;

    assign bad_seq = !$onehot0({cout, c_load, cin, conv})
                   || (cin && !in_left)
                   || (cout && cout_done);
    assign seq_err_d = seq_err_q || bad_seq;
    assign seq_err   = seq_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= seq_err_d;
        end
    end
`endif

endmodule
